// File: rtl/tpu_bridge_pkg.sv
// Shared types and constants for the TPU config bridge: FSM states, config
// register map, config bank layout and the MLP status encodings.
package tpu_bridge_pkg;

  typedef enum logic [1:0] {
    B_IDLE  = 2'd0,
    B_APPLY = 2'd1,
    B_START = 2'd2,
    B_RUN   = 2'd3
  } bridge_state_e;

  localparam logic [2:0] CFG_ADDR_GAIN      = 3'd0;
  localparam logic [2:0] CFG_ADDR_BIAS      = 3'd1;
  localparam logic [2:0] CFG_ADDR_SHIFT     = 3'd2;
  localparam logic [2:0] CFG_ADDR_INV_SCALE = 3'd3;
  localparam logic [2:0] CFG_ADDR_ZERO_PT   = 3'd4;
  localparam logic [2:0] CFG_ADDR_COMMIT    = 3'd5;

  // Encodings must track mlp_top's state register.
  localparam logic [3:0] MLP_ST_IDLE = 4'd0;
  localparam logic [3:0] MLP_ST_DONE = 4'd7;

  typedef struct packed {
    logic signed [15:0] gain;
    logic signed [31:0] bias;
    logic        [4:0]  shift;
    logic signed [15:0] inv_scale;
    logic signed [7:0]  zero_pt;
  } cfg_t;

  // Q8 identity: x * 256 >> 8, unit requantisation scale, no offset.
  localparam cfg_t CFG_RESET = '{
    gain:      16'sd256,
    bias:      32'sd0,
    shift:     5'd8,
    inv_scale: 16'sd256,
    zero_pt:   8'sd0
  };

endpackage

// File: rtl/tpu_cfg_bridge_if.sv
// Controller-side and MLP-side signal bundle of the config bridge.
// The bridge uses the slave view; the controller/MLP environment uses master.
interface tpu_cfg_bridge_if #(
  parameter int N_COLS = 2,
  parameter int DATA_W = 8,
  parameter int ACT_W  = 16,
  parameter int ACC_W  = 32
);
  import tpu_bridge_pkg::*;

  localparam int COL_W = $clog2(N_COLS);

  // Controller side
  logic              ctrl_wf_push;
  logic [COL_W-1:0]  ctrl_wf_col;
  logic [DATA_W-1:0] ctrl_wf_data_in;
  logic              ctrl_wf_reset;
  logic              ctrl_init_act_valid;
  logic [ACT_W-1:0]  ctrl_init_act_data;
  logic              ctrl_weights_ready;
  logic              ctrl_start_mlp;
  logic              ctrl_cfg_we;
  logic [2:0]        ctrl_cfg_addr;
  logic [31:0]       ctrl_cfg_wdata;
  logic [COL_W-1:0]  ctrl_res_sel;
  logic              ctrl_res_ack;
  logic              ctrl_busy;
  logic              ctrl_cfg_pending;
  logic              ctrl_res_valid;
  logic [ACC_W-1:0]  ctrl_res_data;
  logic [3:0]        ctrl_mlp_state;
  logic [4:0]        ctrl_mlp_cycle_cnt;

  // MLP side
  logic [N_COLS-1:0]       mlp_wf_push;
  logic [DATA_W-1:0]       mlp_wf_data_in;
  logic                    mlp_wf_reset;
  logic                    mlp_init_act_valid;
  logic [ACT_W-1:0]        mlp_init_act_data;
  logic                    mlp_start_mlp;
  logic                    mlp_weights_ready;
  logic signed [15:0]      mlp_norm_gain;
  logic signed [31:0]      mlp_norm_bias;
  logic [4:0]              mlp_norm_shift;
  logic signed [15:0]      mlp_q_inv_scale;
  logic signed [7:0]       mlp_q_zero_point;
  logic [3:0]              mlp_state_in;
  logic [4:0]              mlp_cycle_cnt_in;
  logic [N_COLS*ACC_W-1:0] mlp_acc_in;

  // Debug view of the bridge FSM
  bridge_state_e bridge_state;

  modport slave (
    input  ctrl_wf_push, ctrl_wf_col, ctrl_wf_data_in, ctrl_wf_reset,
           ctrl_init_act_valid, ctrl_init_act_data, ctrl_weights_ready,
           ctrl_start_mlp, ctrl_cfg_we, ctrl_cfg_addr, ctrl_cfg_wdata,
           ctrl_res_sel, ctrl_res_ack,
           mlp_state_in, mlp_cycle_cnt_in, mlp_acc_in,
    output ctrl_busy, ctrl_cfg_pending, ctrl_res_valid, ctrl_res_data,
           ctrl_mlp_state, ctrl_mlp_cycle_cnt,
           mlp_wf_push, mlp_wf_data_in, mlp_wf_reset, mlp_init_act_valid,
           mlp_init_act_data, mlp_start_mlp, mlp_weights_ready,
           mlp_norm_gain, mlp_norm_bias, mlp_norm_shift,
           mlp_q_inv_scale, mlp_q_zero_point, bridge_state
  );

  modport master (
    output ctrl_wf_push, ctrl_wf_col, ctrl_wf_data_in, ctrl_wf_reset,
           ctrl_init_act_valid, ctrl_init_act_data, ctrl_weights_ready,
           ctrl_start_mlp, ctrl_cfg_we, ctrl_cfg_addr, ctrl_cfg_wdata,
           ctrl_res_sel, ctrl_res_ack,
           mlp_state_in, mlp_cycle_cnt_in, mlp_acc_in,
    input  ctrl_busy, ctrl_cfg_pending, ctrl_res_valid, ctrl_res_data,
           ctrl_mlp_state, ctrl_mlp_cycle_cnt,
           mlp_wf_push, mlp_wf_data_in, mlp_wf_reset, mlp_init_act_valid,
           mlp_init_act_data, mlp_start_mlp, mlp_weights_ready,
           mlp_norm_gain, mlp_norm_bias, mlp_norm_shift,
           mlp_q_inv_scale, mlp_q_zero_point, bridge_state
  );

endinterface

// File: rtl/tpu_cfg_regs.sv
// Activation-pipeline config: shadow bank written any time, active bank
// loaded from shadow only when the bridge FSM pulses apply_i.
module tpu_cfg_regs
  import tpu_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we_i,
  input  logic [2:0]  cfg_addr_i,
  input  logic [31:0] cfg_wdata_i,
  input  logic        apply_i,
  output cfg_t        active_o,
  output logic        pending_o
);

  cfg_t shadow_q, shadow_d;
  cfg_t active_q, active_d;
  logic pending_q, pending_d;
  logic commit;

  assign commit = cfg_we_i && (cfg_addr_i == CFG_ADDR_COMMIT);

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (cfg_we_i) begin
      case (cfg_addr_i)
        CFG_ADDR_GAIN:      shadow_d.gain      = cfg_wdata_i[15:0];
        CFG_ADDR_BIAS:      shadow_d.bias      = cfg_wdata_i;
        CFG_ADDR_SHIFT:     shadow_d.shift     = cfg_wdata_i[4:0];
        CFG_ADDR_INV_SCALE: shadow_d.inv_scale = cfg_wdata_i[15:0];
        CFG_ADDR_ZERO_PT:   shadow_d.zero_pt   = cfg_wdata_i[7:0];
        default: ;
      endcase
    end
    if (apply_i) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    // A commit landing on the apply cycle is kept so it is not lost.
    if (commit) pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= CFG_RESET;
      active_q  <= CFG_RESET;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign active_o  = active_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/tpu_cfg_bridge.sv
// Controller <-> MLP bridge: registered weight/activation forwarding, MLP
// start sequencing with config commit, and a per-column result buffer.
module tpu_cfg_bridge
  import tpu_bridge_pkg::*;
#(
  parameter int N_COLS = 2,
  parameter int DATA_W = 8,
  parameter int ACT_W  = 16,
  parameter int ACC_W  = 32
) (
  input logic             clk,
  input logic             rst_n,
  tpu_cfg_bridge_if.slave bus
);

  localparam int COL_W = $clog2(N_COLS);

  bridge_state_e state_q, state_d;
  logic          launched_q, launched_d;
  logic          apply;
  logic          capture;
  logic          commit_now;
  logic          busy;
  cfg_t          active_cfg;
  logic          pending;

  logic [N_COLS-1:0] wf_push_q, wf_push_d;
  logic [DATA_W-1:0] wf_data_q;
  logic              wf_reset_q;
  logic              init_valid_q;
  logic [ACT_W-1:0]  init_data_q;
  logic              weights_ready_q;

  logic [ACC_W-1:0]  res_q [N_COLS];
  logic              res_valid_q, res_valid_d;
  logic [ACC_W-1:0]  res_data;

  tpu_cfg_regs u_cfg_regs (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we_i    (bus.ctrl_cfg_we),
    .cfg_addr_i  (bus.ctrl_cfg_addr),
    .cfg_wdata_i (bus.ctrl_cfg_wdata),
    .apply_i     (apply),
    .active_o    (active_cfg),
    .pending_o   (pending)
  );

  assign commit_now = bus.ctrl_cfg_we && (bus.ctrl_cfg_addr == CFG_ADDR_COMMIT);
  assign busy       = (state_q != B_IDLE);

  // launched_q remembers whether APPLY was entered by a start request.
  always_comb begin
    state_d    = state_q;
    launched_d = launched_q;
    apply      = 1'b0;
    capture    = 1'b0;
    case (state_q)
      B_IDLE: begin
        if (bus.ctrl_start_mlp && bus.ctrl_weights_ready) begin
          launched_d = 1'b1;
          state_d    = (pending || commit_now) ? B_APPLY : B_START;
        end else if (pending && !bus.ctrl_start_mlp) begin
          launched_d = 1'b0;
          state_d    = B_APPLY;
        end
      end
      B_APPLY: begin
        apply   = 1'b1;
        state_d = launched_q ? B_START : B_IDLE;
      end
      B_START: state_d = B_RUN;
      B_RUN: begin
        if (bus.mlp_state_in == MLP_ST_DONE) begin
          capture = 1'b1;
          state_d = B_IDLE;
        end
      end
      default: state_d = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= B_IDLE;
      launched_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      launched_q <= launched_d;
    end
  end

  always_comb begin
    wf_push_d = '0;
    if (bus.ctrl_wf_push && !busy && (int'(bus.ctrl_wf_col) < N_COLS))
      wf_push_d = {{(N_COLS-1){1'b0}}, 1'b1} << bus.ctrl_wf_col;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wf_push_q       <= '0;
      wf_data_q       <= '0;
      wf_reset_q      <= 1'b0;
      init_valid_q    <= 1'b0;
      init_data_q     <= '0;
      weights_ready_q <= 1'b0;
    end else begin
      wf_push_q       <= wf_push_d;
      wf_data_q       <= bus.ctrl_wf_data_in;
      wf_reset_q      <= bus.ctrl_wf_reset;
      init_valid_q    <= bus.ctrl_init_act_valid && !busy;
      init_data_q     <= bus.ctrl_init_act_data;
      weights_ready_q <= bus.ctrl_weights_ready;
    end
  end

  // Result handshake: ctrl_res_valid rises on capture and holds until the
  // controller pulses ctrl_res_ack; a capture in the ack cycle wins and
  // a capture while still valid overwrites the unread result.
  always_comb begin
    res_valid_d = res_valid_q;
    if (bus.ctrl_res_ack) res_valid_d = 1'b0;
    if (capture)          res_valid_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      for (int c = 0; c < N_COLS; c++) res_q[c] <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      if (capture) begin
        for (int c = 0; c < N_COLS; c++) res_q[c] <= bus.mlp_acc_in[c*ACC_W +: ACC_W];
      end
    end
  end

  always_comb begin
    res_data = '0;
    if (int'(bus.ctrl_res_sel) < N_COLS) res_data = res_q[bus.ctrl_res_sel];
  end

  assign bus.ctrl_busy          = busy;
  assign bus.ctrl_cfg_pending   = pending;
  assign bus.ctrl_res_valid     = res_valid_q;
  assign bus.ctrl_res_data      = res_data;
  assign bus.ctrl_mlp_state     = bus.mlp_state_in;
  assign bus.ctrl_mlp_cycle_cnt = bus.mlp_cycle_cnt_in;

  assign bus.mlp_wf_push        = wf_push_q;
  assign bus.mlp_wf_data_in     = wf_data_q;
  assign bus.mlp_wf_reset       = wf_reset_q;
  assign bus.mlp_init_act_valid = init_valid_q;
  assign bus.mlp_init_act_data  = init_data_q;
  assign bus.mlp_start_mlp      = (state_q == B_START);
  assign bus.mlp_weights_ready  = weights_ready_q;
  assign bus.mlp_norm_gain      = active_cfg.gain;
  assign bus.mlp_norm_bias      = active_cfg.bias;
  assign bus.mlp_norm_shift     = active_cfg.shift;
  assign bus.mlp_q_inv_scale    = active_cfg.inv_scale;
  assign bus.mlp_q_zero_point   = active_cfg.zero_pt;
  assign bus.bridge_state       = state_q;

endmodule
